dma_row_writer: RTL and testbench

- Parametrised DMA that takes decompressed rows from the decompressor through a valid/ready handshake.
- Slices each row into BLK_W-bit blocks, least-significant block first, and writes them sequentially into block RAM.
- Transfer is programmable: base address, row stride and row count, all captured at start.
- Sits between the decompression unit and the feature/weight RAM; signals per-row and per-transfer completion to the controller.

---
 rtl/dma_row_writer.sv | 206 ++++++++++++++++++++
 tb/tb_dma_row_writer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_row_writer.sv
// dma_row_writer
//   Accepts decompressed rows over a valid/ready handshake and writes each row
//   into block RAM as WORDS = ROW_W/BLK_W consecutive BLK_W-bit words. The
//   least-significant block goes first. Row start addresses advance by a
//   programmable stride from a programmable base address. The row count,
//   base and stride are captured when a transfer starts.
//
//   Optional feature (macro DMA_SKIP_ZERO_EN): all-zero blocks suppress the
//   RAM enable/write strobe for their cycle. The address sequence and timing
//   are unchanged.
//
//   Ports
//     clk, rst           clock (rising edge), asynchronous active-low reset
//     start              one-cycle transfer request, sampled only when idle
//     base_addr          first RAM address (captured on start)
//     row_stride         address distance between row starts (captured on start)
//     num_rows           number of rows to transfer (captured on start)
//     row_in/row_valid   incoming row and its valid flag
//     row_ready          high while waiting for the next row
//     ram_enable/write   RAM strobes, high only on write cycles
//     ram_address        RAM address (holds its last value between writes)
//     output_to_ram      RAM write data (holds its last value between writes)
//     busy               transfer in progress
//     row_done           one-cycle pulse after the last write of each row
//     done               one-cycle pulse ending the transfer
module dma_row_writer #(
    parameter int ROW_W  = 16,
    parameter int BLK_W  = 4,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] row_stride,
    input  logic [CNT_W-1:0]  num_rows,
    input  logic [ROW_W-1:0]  row_in,
    input  logic              row_valid,
    output logic              row_ready,
    output logic              ram_enable,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BLK_W-1:0]  output_to_ram,
    output logic              busy,
    output logic              row_done,
    output logic              done
);

    localparam int WORDS = ROW_W / BLK_W;
    localparam int JW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ROW, WRITE, FINISH} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [CNT_W-1:0]    nrows_q, nrows_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [CNT_W-1:0]    r_q, r_d;
    logic [JW-1:0]       j_q, j_d;
    logic [ROW_W-1:0]    shift_q, shift_d;
    logic                row_ready_q, row_ready_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BLK_W-1:0]    data_q, data_d;
    logic                busy_q, busy_d;
    logic                row_done_q, row_done_d;
    logic                done_q, done_d;

    logic [JW-1:0]       j_inc;
    logic [CNT_W-1:0]    r_inc;

    assign j_inc = j_q + 1'b1;
    assign r_inc = r_q + 1'b1;

    // Every output is a flop; the *_d values describe what the outputs must
    // show in the state being entered, so they are derived from state_d.
    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        nrows_d    = nrows_q;
        row_base_d = row_base_q;
        r_d        = r_q;
        j_d        = j_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = 1'b0;
        row_done_d = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    stride_d   = row_stride;
                    nrows_d    = num_rows;
                    row_base_d = base_addr;
                    r_d        = '0;
                    j_d        = '0;
                    if (num_rows == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_ROW;
                    end
                end
            end

            WAIT_ROW: begin
                // Word 0 is presented straight from row_in on the handshake;
                // the shift register keeps the remaining words.
                if (row_valid) begin
                    state_d = WRITE;
                    addr_d  = row_base_q;
                    data_d  = row_in[BLK_W-1:0];
                    shift_d = row_in >> BLK_W;
                    j_d     = '0;
                    wr_d    = 1'b1;
                end
            end

            WRITE: begin
                if (j_q == J_LAST) begin
                    row_done_d = 1'b1;
                    r_d        = r_inc;
                    row_base_d = row_base_q + stride_q;
                    j_d        = '0;
                    if (r_inc == nrows_q) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT_ROW;
                    end
                end else begin
                    j_d     = j_inc;
                    addr_d  = row_base_q + ADDR_W'(j_inc);
                    data_d  = shift_q[BLK_W-1:0];
                    shift_d = shift_q >> BLK_W;
                    wr_d    = 1'b1;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef DMA_SKIP_ZERO_EN
        if (data_d == '0) begin
            wr_d = 1'b0;
        end
`endif

        row_ready_d = (state_d == WAIT_ROW);
        busy_d      = (state_d == WAIT_ROW) || (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            stride_q    <= '0;
            nrows_q     <= '0;
            row_base_q  <= '0;
            r_q         <= '0;
            j_q         <= '0;
            shift_q     <= '0;
            row_ready_q <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            row_done_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stride_q    <= stride_d;
            nrows_q     <= nrows_d;
            row_base_q  <= row_base_d;
            r_q         <= r_d;
            j_q         <= j_d;
            shift_q     <= shift_d;
            row_ready_q <= row_ready_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            row_done_q  <= row_done_d;
            done_q      <= done_d;
        end
    end

    assign row_ready     = row_ready_q;
    assign ram_enable    = wr_q;
    assign ram_write     = wr_q;
    assign ram_address   = addr_q;
    assign output_to_ram = data_q;
    assign busy          = busy_q;
    assign row_done      = row_done_q;
    assign done          = done_q;

endmodule

// File: tb/tb_dma_row_writer.sv
module tb_dma_row_writer;

`ifdef DMA_SKIP_ZERO_EN
    localparam bit SK = 1'b1;
`else
    localparam bit SK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic [15:0] row_stride = '0;
    logic [7:0]  num_rows = '0;
    logic [15:0] row_in = '0;
    logic        row_valid = 1'b0;
    logic        row_ready, ram_enable, ram_write, busy, row_done, done;
    logic [15:0] ram_address;
    logic [3:0]  output_to_ram;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dma_row_writer dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .row_stride(row_stride), .num_rows(num_rows), .row_in(row_in),
        .row_valid(row_valid), .row_ready(row_ready), .ram_enable(ram_enable),
        .ram_write(ram_write), .ram_address(ram_address),
        .output_to_ram(output_to_ram), .busy(busy), .row_done(row_done),
        .done(done)
    );

    typedef struct {
        logic        st;
        logic [15:0] base;
        logic [15:0] stride;
        logic [7:0]  n;
        logic        vld;
        logic [15:0] row;
        logic        rdy, en, bsy, rd, dn;
        logic [15:0] addr;
        logic [3:0]  data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int st, input int base, input int stride,
                                input int n, input int vld, input int row,
                                input int rdy, input int en, input int bsy,
                                input int rd, input int dn, input int addr,
                                input int data);
        vec_t v;
        v.st = 1'(st); v.base = 16'(base); v.stride = 16'(stride);
        v.n = 8'(n); v.vld = 1'(vld); v.row = 16'(row);
        v.rdy = 1'(rdy); v.en = 1'(en); v.bsy = 1'(bsy); v.rd = 1'(rd);
        v.dn = 1'(dn); v.addr = 16'(addr); v.data = 4'(data);
        return v;
    endfunction

    // {row_ready, ram_enable, ram_write, busy, row_done, done, addr, data}
    function automatic logic [25:0] outs();
        return {row_ready, ram_enable, ram_write, busy, row_done, done,
                ram_address, output_to_ram};
    endfunction

    task automatic check(input string name, input logic [25:0] got,
                         input logic [25:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (rdy,en,wr,busy,rd,dn|addr|data)",
                     name, got, exp);
        end
    endtask

    task automatic drive_idle();
        start = 1'b0; row_valid = 1'b0; row_in = '0;
        base_addr = '0; row_stride = '0; num_rows = '0;
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            start = v.st; base_addr = v.base; row_stride = v.stride;
            num_rows = v.n; row_valid = v.vld; row_in = v.row;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), outs(),
                  {v.rdy, v.en, v.en, v.bsy, v.rd, v.dn, v.addr, v.data});
        end
        tbl.delete();
    endtask

    initial begin
        int dn_cnt;
        int bsy_cnt;

        #1;
        check("reset_outputs", outs(), 26'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        // base 0x10, stride 4, two rows
        tbl.push_back(mk(1, 'h10, 4, 2, 0, 0,        1, 0, 1, 0, 0, 'h00, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'hABCD,      0, 1, 1, 0, 0, 'h10, 'hD));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h11, 'hC));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h12, 'hB));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h13, 'hA));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           1, 0, 1, 1, 0, 'h13, 'hA));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h1234,      0, 1, 1, 0, 0, 'h14, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h15, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h16, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h17, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 1, 'h17, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 'h17, 1));
        run_table("basic");

        // zero rows: straight to FINISH, never ready
        tbl.push_back(mk(1, 'h500, 3, 0, 0, 0,       0, 0, 0, 0, 1, 'h17, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'hFFFF,      0, 0, 0, 0, 0, 'h17, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 'h17, 1));
        run_table("zero_rows");

        // address wrap, sparse row 0x00F0
        tbl.push_back(mk(1, 'hFFFE, 8, 1, 0, 0,      1, 0, 1, 0, 0, 'h17, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h00F0,      0, !SK, 1, 0, 0, 'hFFFE, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'hFFFF, 'hF));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, !SK, 1, 0, 0, 'h0000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, !SK, 1, 0, 0, 'h0001, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 1, 'h0001, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 'h0001, 0));
        run_table("wrap");

        // stall in WAIT_ROW for five cycles, then row 0x5A5A
        tbl.push_back(mk(1, 'h200, 1, 1, 0, 0,       1, 0, 1, 0, 0, 'h0001, 0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 0, 0, 0, 0, 'hFFFF,  1, 0, 1, 0, 0, 'h0001, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h5A5A,      0, 1, 1, 0, 0, 'h200, 'hA));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h201, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h202, 'hA));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h203, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 1, 'h203, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 'h203, 5));
        run_table("stall");

        // reset during the second write of a three-row transfer
        tbl.push_back(mk(1, 'h100, 'h10, 3, 0, 0,   1, 0, 1, 0, 0, 'h203, 5));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h1111,      0, 1, 1, 0, 0, 'h100, 1));
        run_table("rst_pre");
        drive_idle();
        @(posedge clk);
        #1;
        check("rst_second_write", outs(), {6'b011100, 16'h0101, 4'h1});
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_clear", outs(), 26'h0);
        @(posedge clk);
        #1;
        check("rst_held", outs(), 26'h0);
        rst = 1'b1;
        dn_cnt = 0;
        bsy_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) dn_cnt++;
            if (busy || ram_enable) bsy_cnt++;
        end
        check("rst_no_done", 26'(dn_cnt), 26'h0);
        check("rst_no_activity", 26'(bsy_cnt), 26'h0);

        tbl.push_back(mk(1, 'h300, 4, 1, 0, 0,       1, 0, 1, 0, 0, 'h000, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h4321,      0, 1, 1, 0, 0, 'h300, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h301, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h302, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h303, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 1, 'h303, 4));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 'h303, 4));
        run_table("rst_restart");

        // start pulses while busy carry different parameters and are ignored
        tbl.push_back(mk(1, 'h40, 'h20, 2, 0, 0,     1, 0, 1, 0, 0, 'h303, 4));
        tbl.push_back(mk(1, 'h900, 1, 5, 1, 'h8765,  0, 1, 1, 0, 0, 'h40, 5));
        tbl.push_back(mk(1, 'h900, 1, 5, 0, 0,       0, 1, 1, 0, 0, 'h41, 6));
        tbl.push_back(mk(1, 'h900, 1, 5, 0, 0,       0, 1, 1, 0, 0, 'h42, 7));
        tbl.push_back(mk(1, 'h900, 1, 5, 0, 0,       0, 1, 1, 0, 0, 'h43, 8));
        tbl.push_back(mk(1, 'h900, 1, 5, 0, 0,       1, 0, 1, 1, 0, 'h43, 8));
        tbl.push_back(mk(0, 0, 0, 0, 1, 'h1357,      0, 1, 1, 0, 0, 'h60, 7));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h61, 5));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h62, 3));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 1, 1, 0, 0, 'h63, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 1, 1, 'h63, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,           0, 0, 0, 0, 0, 'h63, 1));
        run_table("start_busy");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
